// File: rtl/pid_steering_controller.sv
// pid_steering_controller
//   Turns each frame's signed lateral error into a saturated steering
//   correction using a sequential PID computation (one FSM state per step),
//   and mixes that correction into left/right wheel speed commands.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       run; low stops the controller and clears all state
//   error        signed lateral error (positive = path left of centre)
//   error_ready  error valid; a rising edge starts one computation
//   kp, ki, kd   unsigned gains, FRAC_BITS fractional bits
//   busy         FSM not in IDLE
//   control      signed saturated correction (held between samples)
//   left_speed   left wheel command, 0..SPEED_MAX (held between samples)
//   right_speed  right wheel command, 0..SPEED_MAX (held between samples)
//   out_valid    one-cycle strobe, new outputs
//
// Build option
//   PID_ANTIWINDUP_EN  conditional integration: the integrator is frozen
//                      while the previous control was saturated and the new
//                      error would push further in the same direction.
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | waiting for a rising edge of error_ready
// PTERM  | p = kp * e
// ITERM  | integral update (clamped), i = ki * integral
// DTERM  | d = kd * (e - prev_error), history update
// SUM    | scale, saturate control, record saturation
// MIX    | publish control and wheel speeds together
// DONE   | out_valid strobe
module pid_steering_controller #(
  parameter int FRAC_BITS  = 4,
  parameter int INT_LIMIT  = 8192,
  parameter int OUT_LIMIT  = 300,
  parameter int BASE_SPEED = 500,
  parameter int SPEED_MAX  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] error,
  input  logic        error_ready,
  input  logic [7:0]  kp,
  input  logic [7:0]  ki,
  input  logic [7:0]  kd,
  output logic        busy,
  output logic [15:0] control,
  output logic [10:0] left_speed,
  output logic [10:0] right_speed,
  output logic        out_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_PTERM, S_ITERM, S_DTERM, S_SUM, S_MIX, S_DONE
  } state_t;

  localparam logic signed [31:0] INT_HI  = 32'(INT_LIMIT);
  localparam logic signed [31:0] INT_LO  = -INT_HI;
  localparam logic signed [47:0] OUT_HI  = 48'(OUT_LIMIT);
  localparam logic signed [47:0] OUT_LO  = -OUT_HI;
  localparam logic signed [17:0] BASE_S  = 18'(BASE_SPEED);
  localparam logic signed [17:0] MAX_S   = 18'(SPEED_MAX);

  state_t state, state_nxt;

  logic                 ready_q;
  logic                 trigger;
  logic signed [15:0]   e_q;
  logic signed [15:0]   prev_error;
  logic [7:0]           kp_q, ki_q, kd_q;
  logic signed [31:0]   integral;
  logic                 first_sample;
  logic signed [47:0]   p_q, i_q, d_q;
  logic signed [15:0]   ctrl_q;
  logic                 sat_q;

  logic signed [31:0]   err_s;
  logic signed [15:0]   err_sat;
  logic signed [31:0]   int_sum, int_clamped, int_nxt;
  logic                 hold_int;
  logic signed [47:0]   p_calc, i_calc, d_calc;
  logic signed [16:0]   de;
  logic signed [47:0]   sum_all, sum_sh;
  logic signed [15:0]   ctrl_calc;
  logic                 sat_calc;
  logic signed [17:0]   ctrl_ext, left_raw, right_raw;

  function automatic logic [10:0] clamp_speed(input logic signed [17:0] v);
    if (v < 18'sd0)
      return 11'd0;
    else if (v > MAX_S)
      return MAX_S[10:0];
    else
      return v[10:0];
  endfunction

  // ready_q keeps tracking the input even while busy, so a level held high
  // across the whole computation never looks like a fresh edge.
  assign trigger = enable && (state == S_IDLE) && error_ready && !ready_q;

  always_comb begin
    err_s = $signed(error);
    if (err_s > 32'sd32767)
      err_sat = 16'sd32767;
    else if (err_s < -32'sd32767)
      err_sat = -16'sd32767;
    else
      err_sat = err_s[15:0];
  end

  always_comb begin
    int_sum = integral + $signed({{16{e_q[15]}}, e_q});
    if (int_sum > INT_HI)
      int_clamped = INT_HI;
    else if (int_sum < INT_LO)
      int_clamped = INT_LO;
    else
      int_clamped = int_sum;
`ifdef PID_ANTIWINDUP_EN
    // control still holds the previous sample's value during ITERM
    hold_int = sat_q && (e_q != '0) && (e_q[15] == control[15]);
`else
    hold_int = 1'b0;
`endif
    int_nxt = hold_int ? integral : int_clamped;
  end

  always_comb begin
    p_calc = $signed({40'b0, kp_q}) * $signed({{32{e_q[15]}}, e_q});
    i_calc = $signed({40'b0, ki_q}) * $signed({{16{int_nxt[31]}}, int_nxt});
    de     = $signed({e_q[15], e_q}) - $signed({prev_error[15], prev_error});
    d_calc = first_sample ? '0 : $signed({40'b0, kd_q}) * $signed({{31{de[16]}}, de});
  end

  always_comb begin
    sum_all = p_q + i_q + d_q;
    sum_sh  = sum_all >>> FRAC_BITS;
    if (sum_sh > OUT_HI) begin
      ctrl_calc = OUT_HI[15:0];
      sat_calc  = 1'b1;
    end else if (sum_sh < OUT_LO) begin
      ctrl_calc = OUT_LO[15:0];
      sat_calc  = 1'b1;
    end else begin
      ctrl_calc = sum_sh[15:0];
      sat_calc  = 1'b0;
    end
    ctrl_ext  = {{2{ctrl_q[15]}}, ctrl_q};
    left_raw  = BASE_S - ctrl_ext;
    right_raw = BASE_S + ctrl_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    out_valid = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (trigger) state_nxt = S_PTERM;
        S_PTERM: state_nxt = S_ITERM;
        S_ITERM: state_nxt = S_DTERM;
        S_DTERM: state_nxt = S_SUM;
        S_SUM:   state_nxt = S_MIX;
        S_MIX:   state_nxt = S_DONE;
        S_DONE: begin
          state_nxt = S_IDLE;
          out_valid = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q      <= 1'b0;
      e_q          <= '0;
      prev_error   <= '0;
      kp_q         <= '0;
      ki_q         <= '0;
      kd_q         <= '0;
      integral     <= '0;
      first_sample <= 1'b1;
      p_q          <= '0;
      i_q          <= '0;
      d_q          <= '0;
      ctrl_q       <= '0;
      sat_q        <= 1'b0;
      control      <= '0;
      left_speed   <= '0;
      right_speed  <= '0;
    end else begin
      ready_q <= error_ready;
      if (!enable) begin
        integral     <= '0;
        prev_error   <= '0;
        first_sample <= 1'b1;
        sat_q        <= 1'b0;
        control      <= '0;
        left_speed   <= '0;
        right_speed  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (trigger) begin
              e_q  <= err_sat;
              kp_q <= kp;
              ki_q <= ki;
              kd_q <= kd;
            end
          end
          S_PTERM: p_q <= p_calc;
          S_ITERM: begin
            integral <= int_nxt;
            i_q      <= i_calc;
          end
          S_DTERM: begin
            d_q          <= d_calc;
            prev_error   <= e_q;
            first_sample <= 1'b0;
          end
          S_SUM: begin
            ctrl_q <= ctrl_calc;
            sat_q  <= sat_calc;
          end
          S_MIX: begin
            control     <= ctrl_q;
            left_speed  <= clamp_speed(left_raw);
            right_speed <= clamp_speed(right_raw);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pid_steering_controller.sv
module tb_pid_steering_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] error;
  logic        error_ready;
  logic [7:0]  kp, ki, kd;
  logic        busy;
  logic [15:0] control;
  logic [10:0] left_speed, right_speed;
  logic        out_valid;

  int n_chk = 0;
  int n_bad = 0;

  pid_steering_controller dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .error       (error),
    .error_ready (error_ready),
    .kp          (kp),
    .ki          (ki),
    .kd          (kd),
    .busy        (busy),
    .control     (control),
    .left_speed  (left_speed),
    .right_speed (right_speed),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] sctl();
    return {{16{control[15]}}, control};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Edge at cycle N; checks strobe timing, busy window and the results.
  task automatic run_sample(input string tag, input logic [31:0] err,
                            input int exp_ctl, input int exp_l, input int exp_r);
    int early_ov;
    int busy_cnt;
    early_ov = 0;
    busy_cnt = 0;
    error = err;
    error_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) error_ready = 1'b0;
      if (out_valid) early_ov++;
      if (busy) busy_cnt++;
    end
    tick();
    if (busy) busy_cnt++;
    check({tag, " early_ov"}, early_ov, 0);
    check({tag, " ov_n6"}, {31'b0, out_valid}, 1);
    check({tag, " ctl"}, sctl(), exp_ctl);
    check({tag, " left"}, {21'b0, left_speed}, exp_l);
    check({tag, " right"}, {21'b0, right_speed}, exp_r);
    tick();
    check({tag, " busy_cnt"}, busy_cnt, 6);
    check({tag, " idle_n7"}, {31'b0, busy}, 0);
  endtask

  initial begin
    int ov_cnt;
    int ov_pos [2];
    reset = 1'b1;
    enable = 1'b1;
    error = '0;
    error_ready = 1'b0;
    kp = 8'd0; ki = 8'd0; kd = 8'd0;
    tick();
    check("rst ctl", sctl(), 0);
    check("rst left", {21'b0, left_speed}, 0);
    check("rst right", {21'b0, right_speed}, 0);
    check("rst busy", {31'b0, busy}, 0);
    check("rst ov", {31'b0, out_valid}, 0);
    reset = 1'b0;
    tick();

    // proportional only
    kp = 8'd16;
    run_sample("p10", 32'd10, 10, 490, 510);

    // integral accumulation
    do_reset();
    kp = 8'd0; ki = 8'd16; kd = 8'd0;
    run_sample("i1", 32'd20, 20, 480, 520);
    run_sample("i2", 32'd20, 40, 460, 540);
    run_sample("i3", 32'd20, 60, 440, 560);

    // derivative, first sample gives zero
    do_reset();
    kp = 8'd0; ki = 8'd0; kd = 8'd16;
    run_sample("d1", 32'd50, 0, 500, 500);
    run_sample("d2", 32'd30, -20, 520, 480);

    // output saturation
    do_reset();
    kp = 8'd255; ki = 8'd0; kd = 8'd0;
    run_sample("sat+", 32'd1000, 300, 200, 800);
    run_sample("sat-", -32'sd1000, -300, 800, 200);
    kp = 8'd16;
    run_sample("neg5", -32'sd5, -5, 505, 495);

    // input saturation to +/-32767, seen through the derivative
    do_reset();
    kp = 8'd0; ki = 8'd0; kd = 8'd16;
    run_sample("esat0", -32'sd32760, 0, 500, 500);
    run_sample("esatmin", 32'h8000_0000, -7, 507, 493);
    run_sample("esatmax", 32'd100000, 300, 200, 800);

    // integrator clamp, both signs
    do_reset();
    kp = 8'd0; ki = 8'd1; kd = 8'd0;
    run_sample("ic1", 32'd32767, 300, 200, 800);
    run_sample("ic2", -32'sd8192, 0, 500, 500);
    run_sample("ic3", -32'sd32767, -300, 800, 200);
    run_sample("ic4", 32'd8192, 0, 500, 500);

    // level held high gives exactly one result
    do_reset();
    kp = 8'd16; ki = 8'd0; kd = 8'd0;
    error = 32'd7;
    error_ready = 1'b1;
    ov_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      if (out_valid) ov_cnt++;
      tick();
    end
    error_ready = 1'b0;
    tick();
    check("level ov_cnt", ov_cnt, 1);
    check("level ctl", sctl(), 7);

    // edge while busy dropped, edge at N+7 accepted
    ov_cnt = 0;
    ov_pos[0] = -1;
    ov_pos[1] = -1;
    for (int c = 0; c <= 20; c++) begin
      error = (c < 7) ? 32'd3 : 32'd11;
      error_ready = (c == 0) || (c >= 2 && c <= 4) || (c == 7 || c == 8);
      if (out_valid) begin
        if (ov_cnt < 2) ov_pos[ov_cnt] = c;
        ov_cnt++;
      end
      tick();
    end
    error_ready = 1'b0;
    check("busy_edge ov_cnt", ov_cnt, 2);
    check("busy_edge ov1", ov_pos[0], 6);
    check("busy_edge ov2", ov_pos[1], 13);
    check("busy_edge ctl", sctl(), 11);

    // async reset mid-computation
    do_reset();
    kp = 8'd16; ki = 8'd0; kd = 8'd0;
    run_sample("pre_rst", 32'd20, 20, 480, 520);
    kd = 8'd16;
    error = 32'd50;
    error_ready = 1'b1;
    tick();
    error_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("arst ctl", sctl(), 0);
    check("arst left", {21'b0, left_speed}, 0);
    check("arst right", {21'b0, right_speed}, 0);
    check("arst busy", {31'b0, busy}, 0);
    tick();
    reset = 1'b0;
    ov_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) ov_cnt++;
      tick();
    end
    check("arst no_ov", ov_cnt, 0);
    kp = 8'd0;
    run_sample("arst first", 32'd30, 0, 500, 500);

    // enable dropped mid-computation
    do_reset();
    kp = 8'd16; ki = 8'd0; kd = 8'd0;
    run_sample("pre_en", 32'd20, 20, 480, 520);
    kd = 8'd16;
    error = 32'd50;
    error_ready = 1'b1;
    tick();
    error_ready = 1'b0;
    tick();
    tick();
    enable = 1'b0;
    if (out_valid) ov_cnt = 1; else ov_cnt = 0;
    tick();
    check("en ctl", sctl(), 0);
    check("en left", {21'b0, left_speed}, 0);
    check("en right", {21'b0, right_speed}, 0);
    check("en busy", {31'b0, busy}, 0);
    tick();
    enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) ov_cnt++;
      tick();
    end
    check("en no_ov", ov_cnt, 0);
    kp = 8'd0;
    run_sample("en first", 32'd30, 0, 500, 500);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pid_steering_controller.md
Name: pid_steering_controller

Overview:
- Downstream of the mid-line error stage: consumes each frame's signed lateral error and its ready flag.
- Runs a sequential multi-cycle PID computation and produces a saturated steering correction.
- Mixes the correction into left/right wheel speed commands for the PWM motor drivers.
- One result per video frame.

Parameters:
- FRAC_BITS, 4: gains are unsigned fixed point with FRAC_BITS fractional bits; sum is arithmetic-shifted right by FRAC_BITS.
- INT_LIMIT, 8192: integrator clamp magnitude, ±INT_LIMIT.
- OUT_LIMIT, 300: control saturation magnitude, ±OUT_LIMIT.
- BASE_SPEED, 500: nominal wheel speed.
- SPEED_MAX, 1000: upper clamp for each wheel speed.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run; low = stop and clear state
- error  in  32  signed lateral error (positive = path left of centre)
- error_ready  in  1  error valid; level may stay high for many cycles
- kp  in  8  proportional gain
- ki  in  8  integral gain
- kd  in  8  derivative gain
- busy  out  1  FSM not in IDLE
- control  out  16  signed saturated correction
- left_speed  out  11  unsigned left wheel command
- right_speed  out  11  unsigned right wheel command
- out_valid  out  1  one-cycle strobe, new outputs

Behaviour:
- Reset (async) and enable=0 (sync, checked every cycle, overrides everything):
  - FSM goes to IDLE.
  - control=0, left_speed=0, right_speed=0, out_valid=0, busy=0.
  - integral=0, prev_error=0, first_sample=1.
- Sample trigger:
  - The trigger is a rising edge of error_ready (registered previous value; previous-value register resets to 0).
  - Only accepted in IDLE with enable=1.
  - Edges arriving while busy are dropped. A level held high produces exactly one trigger.
- On trigger (cycle N):
  - error is saturated to signed 16-bit (±32767) and latched as e.
  - kp, ki and kd are latched.
- FSM states: IDLE -> PTERM -> ITERM -> DTERM -> SUM -> MIX -> DONE -> IDLE, one cycle each.
  - PTERM: p = kp*e (48-bit signed internal).
  - ITERM: integral = clamp(integral + e, ±INT_LIMIT); i = ki*integral using the new value.
  - DTERM: d = first_sample ? 0 : kd*(e - prev_error); then prev_error <= e, first_sample <= 0.
  - SUM: s = (p + i + d) >>> FRAC_BITS (floor); control = clamp(s, ±OUT_LIMIT); sat flag recorded.
  - MIX: left_speed = clamp(BASE_SPEED - control, 0, SPEED_MAX); right_speed = clamp(BASE_SPEED + control, 0, SPEED_MAX).
  - DONE: out_valid=1 for exactly this cycle.
- Timing:
  - Latency: trigger at cycle N, out_valid high at N+6.
  - busy is high N+1 through N+6.
  - Next trigger is accepted from N+7.
- Output holding:
  - control and the speeds hold their values between samples.
  - All three update together, visible no later than the out_valid cycle.
- Boundary cases:
  - Error of exactly 0 still updates the derivative history.
  - error=-2^31 saturates to -32767.
  - Integral clamps symmetrically.
  - Speeds never wrap: negative results give 0; values above SPEED_MAX give SPEED_MAX.

Optional Feature:
- Macro: PID_ANTIWINDUP_EN.
- Defined: conditional integration. In ITERM, the integral is left unchanged if the previous sample's control was saturated and sign(e) equals sign(previous control). The clamp still applies otherwise.
- Undefined: the integrator always accumulates; the only anti-windup is the ±INT_LIMIT clamp.

Test Plan:
- kp=16, ki=0, kd=0; error=10 edge at N -> out_valid only at N+6; control=10, left=490, right=510.
- ki=16, kp=kd=0; three separate edges with error=20 -> control 20, 40, 60; busy high 6 cycles each.
- kd=16, kp=ki=0; error=50 then 30 -> control 0 (first sample), then -20; left=520, right=480.
- kp=255; error=1000 -> control=300, left=200, right=800. Then error=-1000 -> control=-300, left=800, right=200. Then error=-5 with kp=16 -> control=-5.
- error_ready held high 1000 cycles -> exactly one out_valid. A second rising edge at N+2 (while busy) is ignored. An edge at N+7 is accepted.
- Async reset asserted at N+3, or enable dropped at N+3 -> outputs are 0 on that edge/next cycle and no out_valid. The next sample with kd=16 gives d=0 (first_sample restored).
